// File: rtl/asym_ram_wf_tdp_if.sv
// Port bundle for the asymmetric true-dual-port RAM.
// Port A is the wide side and port B is the narrow side; both share one clock.
interface asym_ram_wf_tdp_if #(
    parameter int unsigned WIDTHA     = 16,
    parameter int unsigned ADDRWIDTHA = 8,
    parameter int unsigned WIDTHB     = 4,
    parameter int unsigned ADDRWIDTHB = 10
);
    logic                  weA;
    logic [ADDRWIDTHA-1:0] addrA;
    logic [WIDTHA-1:0]     diA;
    logic [WIDTHA-1:0]     doA;
    logic                  weB;
    logic [ADDRWIDTHB-1:0] addrB;
    logic [WIDTHB-1:0]     diB;
    logic [WIDTHB-1:0]     doB;

    modport master (
        output weA, addrA, diA, weB, addrB, diB,
        input  doA, doB
    );

    modport slave (
        input  weA, addrA, diA, weB, addrB, diB,
        output doA, doB
    );
endinterface

// File: rtl/asym_ram_wf_tdp.sv
// Asymmetric true-dual-port RAM, write-first on both ports, with a single clock.
// Port A accesses RATIO narrow cells per word, and the lowest nibble maps to the lowest B address.
module asym_ram_wf_tdp #(
    parameter int unsigned WIDTHA     = 16,
    parameter int unsigned SIZEA      = 256,
    parameter int unsigned ADDRWIDTHA = 8,
    parameter int unsigned WIDTHB     = 4,
    parameter int unsigned SIZEB      = 1024,
    parameter int unsigned ADDRWIDTHB = 10
) (
    input logic clk,
    input logic rst_n,
    asym_ram_wf_tdp_if.slave bus
);
    localparam int unsigned RATIO = WIDTHA / WIDTHB;
    localparam int unsigned LOG2R = $clog2(RATIO);

    logic [WIDTHB-1:0]     r_mem [SIZEB];
    logic [WIDTHA-1:0]     r_doA;
    logic [WIDTHB-1:0]     r_doB;
    logic [ADDRWIDTHB-1:0] w_baseA;
    logic [WIDTHA-1:0]     w_rdA;

    assign w_baseA = ADDRWIDTHB'(bus.addrA) << LOG2R;

    // Gather the old (pre-edge) contents of A's word from its narrow cells.
    always_comb begin
        w_rdA = '0;
        for (int unsigned k = 0; k < RATIO; k++) begin
            w_rdA[k*WIDTHB +: WIDTHB] = r_mem[w_baseA + ADDRWIDTHB'(k)];
        end
    end

    // Storage update; B is written last, so it wins any nibble both ports write.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (bus.weA) begin
                for (int unsigned k = 0; k < RATIO; k++) begin
                    r_mem[w_baseA + ADDRWIDTHB'(k)] <= bus.diA[k*WIDTHB +: WIDTHB];
                end
            end
            if (bus.weB) begin
                r_mem[bus.addrB] <= bus.diB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_doA <= '0;
            r_doB <= '0;
        end else begin
            r_doA <= bus.weA ? bus.diA : w_rdA;
            r_doB <= bus.weB ? bus.diB : r_mem[bus.addrB];
        end
    end

    assign bus.doA = r_doA;
    assign bus.doB = r_doB;

    logic w_unused;
    assign w_unused = ^{SIZEA[0]};
endmodule

// File: tb/tb_asym_ram_wf_tdp.sv
// Bench for asym_ram_wf_tdp: directed scenarios followed by a random soak.
// A nibble-array model feeds per-cycle expectations into scoreboard queues.
module tb_asym_ram_wf_tdp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [3:0]  m [1024];
    logic [15:0] qA [$];
    logic [3:0]  qB [$];

    asym_ram_wf_tdp_if bus ();

    asym_ram_wf_tdp dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chkA(input string tag, input logic [15:0] exp);
        checks++;
        assert (bus.doA === exp) else begin
            failures++;
            $error("FAIL %s doA observed=%h expected=%h", tag, bus.doA, exp);
        end
    endtask

    task automatic chkB(input string tag, input logic [3:0] exp);
        checks++;
        assert (bus.doB === exp) else begin
            failures++;
            $error("FAIL %s doB observed=%h expected=%h", tag, bus.doB, exp);
        end
    endtask

    // Drive one cycle, predict from the model, advance one edge and compare.
    task automatic cyc(input logic rst, input logic wa, input logic [7:0] aa,
                       input logic [15:0] da, input logic wb,
                       input logic [9:0] ab, input logic [3:0] db);
        logic [15:0] ea;
        logic [3:0]  eb;
        rst_n     = rst;
        bus.weA   = wa;
        bus.addrA = aa;
        bus.diA   = da;
        bus.weB   = wb;
        bus.addrB = ab;
        bus.diB   = db;
        for (int k = 0; k < 4; k++) ea[k*4 +: 4] = m[int'(aa)*4 + k];
        if (!rst)    ea = 16'h0;
        else if (wa) ea = da;
        if (!rst)    eb = 4'h0;
        else if (wb) eb = db;
        else         eb = m[ab];
        qA.push_back(ea);
        qB.push_back(eb);
        if (rst) begin
            if (wa) for (int k = 0; k < 4; k++) m[int'(aa)*4 + k] = da[k*4 +: 4];
            if (wb) m[ab] = db;
        end
        @(posedge clk);
        #1;
        checks++;
        if (qA.size() == 0 || qB.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", qA.size());
        end else begin
            ea = qA.pop_front();
            eb = qB.pop_front();
            assert (bus.doA === ea && bus.doB === eb) else begin
                failures++;
                $error("FAIL sb_cycle doA=%h/%h doB=%h/%h (observed/expected)",
                       bus.doA, ea, bus.doB, eb);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m[i] = 4'h0;
        bus.weA = 1'b0; bus.addrA = '0; bus.diA = '0;
        bus.weB = 1'b0; bus.addrB = '0; bus.diB = '0;

        // Reset state
        cyc(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 10'h0, 4'h0);
        cyc(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 10'h0, 4'h0);
        chkA("reset_doA", 16'h0000);
        chkB("reset_doB", 4'h0);

        // Clear the array so the model and the storage agree from here on
        for (int i = 0; i < 256; i++) cyc(1'b1, 1'b1, 8'(i), 16'h0, 1'b0, 10'h0, 4'h0);

        // Write-first on A, then read back
        cyc(1'b1, 1'b1, 8'h12, 16'hBEEF, 1'b0, 10'h0, 4'h0);
        chkA("wf_a_write", 16'hBEEF);
        cyc(1'b1, 1'b0, 8'h12, 16'h0, 1'b0, 10'h0, 4'h0);
        chkA("wf_a_read", 16'hBEEF);

        // Cross-width read: nibbles F, E, E, B
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 10'h048, 4'h0); chkB("xw_48", 4'hF);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 10'h049, 4'h0); chkB("xw_49", 4'hE);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 10'h04A, 4'h0); chkB("xw_4A", 4'hE);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 10'h04B, 4'h0); chkB("xw_4B", 4'hB);

        // Narrow-to-wide
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 10'h3FC, 4'h1);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 10'h3FD, 4'h2);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 10'h3FE, 4'h3);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 10'h3FF, 4'h4);
        cyc(1'b1, 1'b0, 8'hFF, 16'h0, 1'b0, 10'h0, 4'h0);
        chkA("n2w_read", 16'h4321);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b1, 10'h3FD, 4'h7);
        chkB("wf_b_write", 4'h7);
        cyc(1'b1, 1'b0, 8'hFF, 16'h0, 1'b1, 10'h3FD, 4'h2);
        chkA("n2w_after_7", 16'h4371);

        // A reads while B writes the same word: old data first, new data next
        cyc(1'b1, 1'b0, 8'hFF, 16'h0, 1'b1, 10'h3FE, 4'hA);
        chkA("coll_rd_old", 16'h4321);
        chkB("coll_wb", 4'hA);
        cyc(1'b1, 1'b0, 8'hFF, 16'h0, 1'b0, 10'h0, 4'h0);
        chkA("coll_rd_new", 16'h4A21);

        // Both ports write an overlapping nibble: B wins the shared nibble
        cyc(1'b1, 1'b1, 8'hFF, 16'h1111, 1'b1, 10'h3FC, 4'h9);
        chkA("ww_own_a", 16'h1111);
        chkB("ww_own_b", 4'h9);
        cyc(1'b1, 1'b0, 8'hFF, 16'h0, 1'b1, 10'h3FC, 4'h9);
        chkA("ww_merge", 16'h1119);

        // Writes are ignored while reset is asserted
        cyc(1'b0, 1'b1, 8'h00, 16'hFFFF, 1'b1, 10'h001, 4'hC);
        chkA("rst_wr_doA", 16'h0000);
        chkB("rst_wr_doB", 4'h0);
        cyc(1'b1, 1'b0, 8'h00, 16'h0, 1'b0, 10'h001, 4'h0);
        chkA("rst_kept_a0", 16'h0000);
        chkB("rst_kept_b1", 4'h0);

        // Random soak; narrow address windows half the time to force collisions
        for (int i = 0; i < 2500; i++) begin
            logic       narrow;
            logic [7:0] aa;
            logic [9:0] ab;
            narrow = 1'($urandom_range(0, 1));
            aa = narrow ? 8'($urandom_range(0, 1)) : 8'($urandom);
            ab = narrow ? 10'($urandom_range(0, 7)) : 10'($urandom);
            cyc(($urandom_range(0, 63) != 0), 1'($urandom), aa, 16'($urandom),
                1'($urandom), ab, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
